// File: rtl/panel_write_arbiter.sv
// Round-robin arbiter that lets NUM_REQ writers share one panel control
// write bus. A requester owns the bus for a whole burst (until its last
// beat) or until it idles for TIMEOUT cycles; accepted beats are forwarded
// onto registered ctrl_* outputs one cycle later.
module panel_write_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int PANEL_COUNT = 6,
  parameter int TIMEOUT     = 1024
) (
  input  logic                           clock,
  input  logic                           resetn,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*PANEL_COUNT-1:0] req_en,
  input  logic [NUM_REQ*4-1:0]           req_wr,
  input  logic [NUM_REQ*16-1:0]          req_addr,
  input  logic [NUM_REQ*24-1:0]          req_wdat,
  output logic [PANEL_COUNT-1:0]         ctrl_en,
  output logic [3:0]                     ctrl_wr,
  output logic [15:0]                    ctrl_addr,
  output logic [23:0]                    ctrl_wdat,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           timeout_pulse
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                 state_reg;
  logic [NUM_REQ-1:0]     grant_reg;
  logic [IDX_W-1:0]       owner_reg;
  logic [IDX_W-1:0]       last_owner_reg;
  logic [15:0]            idle_cnt_reg;
  logic [PANEL_COUNT-1:0] ctrl_en_reg;
  logic [3:0]             ctrl_wr_reg;
  logic [15:0]            ctrl_addr_reg;
  logic [23:0]            ctrl_wdat_reg;
  logic                   timeout_pulse_reg;

  // Per-requester views of the packed input buses.
  logic [PANEL_COUNT-1:0] en_slice   [NUM_REQ];
  logic [3:0]             wr_slice   [NUM_REQ];
  logic [15:0]            addr_slice [NUM_REQ];
  logic [23:0]            wdat_slice [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign en_slice[gi]   = req_en[gi*PANEL_COUNT +: PANEL_COUNT];
      assign wr_slice[gi]   = req_wr[gi*4 +: 4];
      assign addr_slice[gi] = req_addr[gi*16 +: 16];
      assign wdat_slice[gi] = req_wdat[gi*24 +: 24];
    end
  endgenerate

  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             beat_accept;

  // Round-robin search starting just after the previous owner; scanning
  // from the far end lets the nearest valid requester win the last write.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    pick_idx   = last_owner_reg;
    pick_found = 1'b0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = int'(last_owner_reg) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (req_valid[cand_idx]) begin
        pick_idx   = cand_idx;
        pick_found = 1'b1;
      end
    end
  end

  assign beat_accept = (state_reg == OWNED) && req_valid[owner_reg];

  // Ownership FSM, idle timer and registered write-bus outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg         <= IDLE;
      grant_reg         <= '0;
      owner_reg         <= '0;
      last_owner_reg    <= IDX_W'(NUM_REQ - 1);
      idle_cnt_reg      <= '0;
      ctrl_en_reg       <= '0;
      ctrl_wr_reg       <= '0;
      ctrl_addr_reg     <= '0;
      ctrl_wdat_reg     <= '0;
      timeout_pulse_reg <= 1'b0;
    end else begin
      ctrl_en_reg       <= '0;
      timeout_pulse_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pick_found) begin
            state_reg    <= OWNED;
            grant_reg    <= NUM_REQ'(1) << pick_idx;
            owner_reg    <= pick_idx;
            idle_cnt_reg <= '0;
          end
        end
        OWNED: begin
          if (beat_accept) begin
            ctrl_en_reg   <= en_slice[owner_reg];
            ctrl_wr_reg   <= wr_slice[owner_reg];
            ctrl_addr_reg <= addr_slice[owner_reg];
            ctrl_wdat_reg <= wdat_slice[owner_reg];
            idle_cnt_reg  <= '0;
            if (req_last[owner_reg]) begin
              state_reg      <= IDLE;
              grant_reg      <= '0;
              last_owner_reg <= owner_reg;
            end
          end else if (idle_cnt_reg == TIMEOUT_LAST) begin
            // A stalled owner loses the bus so others are not starved.
            state_reg         <= IDLE;
            grant_reg         <= '0;
            last_owner_reg    <= owner_reg;
            timeout_pulse_reg <= 1'b1;
          end else begin
            idle_cnt_reg <= idle_cnt_reg + 16'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready     = (state_reg == OWNED) ? grant_reg : '0;
  assign grant         = grant_reg;
  assign ctrl_en       = ctrl_en_reg;
  assign ctrl_wr       = ctrl_wr_reg;
  assign ctrl_addr     = ctrl_addr_reg;
  assign ctrl_wdat     = ctrl_wdat_reg;
  assign timeout_pulse = timeout_pulse_reg;

endmodule

// File: tb/tb_panel_write_arbiter.sv
// Bench for panel_write_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbitration rules.
module tb_panel_write_arbiter;

  localparam int NR = 2;
  localparam int PC = 6;
  localparam int TO = 8;

  logic              clock = 1'b0;
  logic              resetn = 1'b0;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     req_ready;
  logic [NR*PC-1:0]  req_en;
  logic [NR*4-1:0]   req_wr;
  logic [NR*16-1:0]  req_addr;
  logic [NR*24-1:0]  req_wdat;
  logic [PC-1:0]     ctrl_en;
  logic [3:0]        ctrl_wr;
  logic [15:0]       ctrl_addr;
  logic [23:0]       ctrl_wdat;
  logic [NR-1:0]     grant;
  logic              timeout_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  panel_write_arbiter #(.NUM_REQ(NR), .PANEL_COUNT(PC), .TIMEOUT(TO)) dut (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid), .req_last(req_last), .req_ready(req_ready),
    .req_en(req_en), .req_wr(req_wr), .req_addr(req_addr), .req_wdat(req_wdat),
    .ctrl_en(ctrl_en), .ctrl_wr(ctrl_wr), .ctrl_addr(ctrl_addr), .ctrl_wdat(ctrl_wdat),
    .grant(grant), .timeout_pulse(timeout_pulse)
  );

  // Reference model: owner is an index or -1 when the bus is free.
  int            m_owner, m_last, m_cnt;
  logic [PC-1:0] m_en;
  logic [3:0]    m_wr;
  logic [15:0]   m_addr;
  logic [23:0]   m_wdat;
  logic          m_tp;

  function automatic logic [NR-1:0] m_grant();
    return (m_owner < 0) ? '0 : (NR'(1) << m_owner);
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = NR - 1; m_cnt = 0;
    m_en = '0; m_wr = '0; m_addr = '0; m_wdat = '0; m_tp = 1'b0;
  endtask

  task automatic model_step();
    int found;
    if (!resetn) begin
      model_reset();
      return;
    end
    m_en = '0;
    m_tp = 1'b0;
    if (m_owner < 0) begin
      found = -1;
      for (int k = 1; k <= NR; k++)
        if (found < 0 && req_valid[(m_last + k) % NR]) found = (m_last + k) % NR;
      if (found >= 0) begin
        m_owner = found;
        m_cnt   = 0;
      end
    end else if (req_valid[m_owner]) begin
      m_en   = req_en[m_owner*PC +: PC];
      m_wr   = req_wr[m_owner*4 +: 4];
      m_addr = req_addr[m_owner*16 +: 16];
      m_wdat = req_wdat[m_owner*24 +: 24];
      m_cnt  = 0;
      if (req_last[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end else if (m_cnt == TO - 1) begin
      m_tp    = 1'b1;
      m_last  = m_owner;
      m_owner = -1;
    end else begin
      m_cnt++;
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next one.
  task automatic tick();
    model_step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic set_req(input int i, input logic v, input logic l, input logic [PC-1:0] en,
                         input logic [3:0] wr, input logic [15:0] addr, input logic [23:0] wdat);
    req_valid[i]         = v;
    req_last[i]          = l;
    req_en[i*PC +: PC]   = en;
    req_wr[i*4 +: 4]     = wr;
    req_addr[i*16 +: 16] = addr;
    req_wdat[i*24 +: 24] = wdat;
  endtask

  task automatic clear_reqs();
    req_valid = '0; req_last = '0; req_en = '0;
    req_wr = '0; req_addr = '0; req_wdat = '0;
  endtask

  task automatic do_reset();
    clear_reqs();
    resetn = 1'b0;
    model_reset();
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    clear_reqs();
    resetn = 1'b0;
    model_reset();
    tick();
    n_cmp++;
    if ({grant, req_ready, timeout_pulse} !== '0) begin
      n_bad++;
      $display("FAIL reset_status: got %b want 0", {grant, req_ready, timeout_pulse});
    end
    n_cmp++;
    if ({ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat} !== '0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %h want 0", {ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat});
    end
    resetn = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_single();
    logic [15:0] a;
    do_reset();
    set_req(0, 1'b1, 1'b0, 6'h2A, 4'h5, 16'h0010, 24'h100010);
    n_cmp++;
    if (req_ready !== 2'b00) begin
      n_bad++;
      $display("FAIL single_ready_idle: got %b want 00", req_ready);
    end
    tick();
    n_cmp++;
    if ({grant, req_ready, ctrl_en} !== {2'b01, 2'b01, 6'h00}) begin
      n_bad++;
      $display("FAIL single_arb: got %b want %b", {grant, req_ready, ctrl_en}, {2'b01, 2'b01, 6'h00});
    end
    for (int b = 0; b < 3; b++) begin
      a = 16'h0010 + 16'(b);
      set_req(0, 1'b1, (b == 2), 6'h2A, 4'h5, a, {8'h10, a});
      tick();
      n_cmp++;
      if ({ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat} !== {6'h2A, 4'h5, a, 8'h10, a}) begin
        n_bad++;
        $display("FAIL single_beat%0d: got %h want %h", b, {ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat},
                 {6'h2A, 4'h5, a, 8'h10, a});
      end
      n_cmp++;
      if (grant !== ((b == 2) ? 2'b00 : 2'b01)) begin
        n_bad++;
        $display("FAIL single_grant%0d: got %b", b, grant);
      end
    end
    clear_reqs();
    tick();
    n_cmp++;
    if ({ctrl_en, ctrl_addr, grant} !== {6'h00, 16'h0012, 2'b00}) begin
      n_bad++;
      $display("FAIL single_after: got %h want %h", {ctrl_en, ctrl_addr, grant}, {6'h00, 16'h0012, 2'b00});
    end
    $display("test_single done");
  endtask

  task automatic test_contention();
    logic [1:0]  exp_g [5];
    logic [5:0]  exp_e [5];
    logic [15:0] exp_a [5];
    exp_g = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    exp_e = '{6'h00, 6'h01, 6'h00, 6'h3E, 6'h00};
    exp_a = '{16'h0000, 16'hA000, 16'hA000, 16'hB000, 16'hB000};
    do_reset();
    set_req(0, 1'b1, 1'b1, 6'h01, 4'h1, 16'hA000, 24'hAAAAAA);
    set_req(1, 1'b1, 1'b1, 6'h3E, 4'h2, 16'hB000, 24'hBBBBBB);
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++;
      if ({grant, ctrl_en, ctrl_addr} !== {exp_g[c], exp_e[c], exp_a[c]}) begin
        n_bad++;
        $display("FAIL contention_c%0d: got %h want %h", c, {grant, ctrl_en, ctrl_addr},
                 {exp_g[c], exp_e[c], exp_a[c]});
      end
    end
    clear_reqs();
    $display("test_contention done");
  endtask

  task automatic test_backpressure();
    do_reset();
    set_req(0, 1'b1, 1'b0, 6'h15, 4'h9, 16'h0100, 24'hC0FFEE);
    tick();
    tick();
    set_req(0, 1'b0, 1'b0, 6'h3F, 4'hF, 16'hFFFF, 24'hFFFFFF);
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++;
      if ({ctrl_en, ctrl_addr, ctrl_wdat, grant} !== {6'h00, 16'h0100, 24'hC0FFEE, 2'b01}) begin
        n_bad++;
        $display("FAIL backpressure_gap%0d: got %h want %h", c, {ctrl_en, ctrl_addr, ctrl_wdat, grant},
                 {6'h00, 16'h0100, 24'hC0FFEE, 2'b01});
      end
    end
    set_req(0, 1'b1, 1'b1, 6'h15, 4'h9, 16'h0101, 24'hC0FFEF);
    tick();
    n_cmp++;
    if ({ctrl_en, ctrl_addr, grant} !== {6'h15, 16'h0101, 2'b00}) begin
      n_bad++;
      $display("FAIL backpressure_last: got %h want %h", {ctrl_en, ctrl_addr, grant}, {6'h15, 16'h0101, 2'b00});
    end
    clear_reqs();
    $display("test_backpressure done");
  endtask

  task automatic test_timeout();
    do_reset();
    set_req(0, 1'b1, 1'b0, 6'h07, 4'h3, 16'h0200, 24'h123456);
    set_req(1, 1'b1, 1'b0, 6'h38, 4'hC, 16'h0300, 24'h654321);
    tick();
    tick();
    req_valid[0] = 1'b0;
    for (int c = 0; c < TO; c++) begin
      tick();
      n_cmp++;
      if ({grant, timeout_pulse, ctrl_en} !== ((c == TO - 1) ? {2'b00, 1'b1, 6'h00} : {2'b01, 1'b0, 6'h00})) begin
        n_bad++;
        $display("FAIL timeout_idle%0d: got %b", c, {grant, timeout_pulse, ctrl_en});
      end
    end
    tick();
    n_cmp++;
    if ({grant, timeout_pulse} !== {2'b10, 1'b0}) begin
      n_bad++;
      $display("FAIL timeout_next: got %b want 100", {grant, timeout_pulse});
    end
    tick();
    n_cmp++;
    if ({ctrl_en, ctrl_addr} !== {6'h38, 16'h0300}) begin
      n_bad++;
      $display("FAIL timeout_req1_beat: got %h want %h", {ctrl_en, ctrl_addr}, {6'h38, 16'h0300});
    end
    clear_reqs();
    $display("test_timeout done");
  endtask

  task automatic test_last_on_timeout();
    do_reset();
    set_req(0, 1'b1, 1'b0, 6'h07, 4'h3, 16'h0200, 24'h123456);
    tick();
    tick();
    req_valid[0] = 1'b0;
    for (int c = 0; c < TO - 1; c++) tick();
    set_req(0, 1'b1, 1'b1, 6'h07, 4'h4, 16'h0201, 24'h123457);
    tick();
    n_cmp++;
    if ({ctrl_en, ctrl_wr, ctrl_addr, timeout_pulse, grant} !== {6'h07, 4'h4, 16'h0201, 1'b0, 2'b00}) begin
      n_bad++;
      $display("FAIL last_on_timeout: got %h want %h", {ctrl_en, ctrl_wr, ctrl_addr, timeout_pulse, grant},
               {6'h07, 4'h4, 16'h0201, 1'b0, 2'b00});
    end
    clear_reqs();
    tick();
    n_cmp++;
    if ({timeout_pulse, grant} !== 3'b000) begin
      n_bad++;
      $display("FAIL last_on_timeout_after: got %b want 000", {timeout_pulse, grant});
    end
    $display("test_last_on_timeout done");
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    set_req(0, 1'b1, 1'b1, 6'h11, 4'h1, 16'h0400, 24'h040000);
    tick();
    tick();
    clear_reqs();
    set_req(1, 1'b1, 1'b0, 6'h22, 4'h6, 16'h0500, 24'h050000);
    tick();
    tick();
    n_cmp++;
    if ({ctrl_en, grant} !== {6'h22, 2'b10}) begin
      n_bad++;
      $display("FAIL midreset_beat1: got %h want %h", {ctrl_en, grant}, {6'h22, 2'b10});
    end
    set_req(1, 1'b1, 1'b0, 6'h22, 4'h6, 16'h0501, 24'h050001);
    resetn = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({grant, req_ready, timeout_pulse, ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat} !== '0) begin
      n_bad++;
      $display("FAIL midreset_async: got %h want 0",
               {grant, req_ready, timeout_pulse, ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat});
    end
    tick();
    n_cmp++;
    if ({grant, ctrl_en, ctrl_addr} !== '0) begin
      n_bad++;
      $display("FAIL midreset_held: got %h want 0", {grant, ctrl_en, ctrl_addr});
    end
    set_req(0, 1'b1, 1'b1, 6'h11, 4'h1, 16'h0402, 24'h040002);
    resetn = 1'b1;
    tick();
    n_cmp++;
    if (grant !== 2'b01) begin
      n_bad++;
      $display("FAIL midreset_priority: got %b want 01", grant);
    end
    tick();
    n_cmp++;
    if ({ctrl_en, ctrl_addr} !== {6'h11, 16'h0402}) begin
      n_bad++;
      $display("FAIL midreset_resume: got %h want %h", {ctrl_en, ctrl_addr}, {6'h11, 16'h0402});
    end
    clear_reqs();
    $display("test_reset_mid_burst done");
  endtask

  task automatic test_random();
    logic v, l;
    int   timeouts;
    timeouts = 0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NR; i++) begin
        v = ((c / 50) % 2 == 1) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) != 0);
        l = ($urandom_range(0, 3) == 0);
        set_req(i, v, l, PC'($urandom), 4'($urandom), 16'($urandom), 24'($urandom));
      end
      tick();
      if (m_tp) timeouts++;
      n_cmp++;
      if ({grant, req_ready, timeout_pulse} !== {m_grant(), m_grant(), m_tp}) begin
        n_bad++;
        $display("FAIL random_status c%0d: got %b want %b", c, {grant, req_ready, timeout_pulse},
                 {m_grant(), m_grant(), m_tp});
      end
      n_cmp++;
      if ({ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat} !== {m_en, m_wr, m_addr, m_wdat}) begin
        n_bad++;
        $display("FAIL random_ctrl c%0d: got %h want %h", c, {ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat},
                 {m_en, m_wr, m_addr, m_wdat});
      end
    end
    clear_reqs();
    $display("test_random done, %0d timeouts expected by model", timeouts);
  endtask

  initial begin
    clear_reqs();
    model_reset();
    @(negedge clock);
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_timeout();
    test_last_on_timeout();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
